// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding mux selects and the
// multi-cycle Execute FSM state encoding.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_mc_stall.sv
// Multi-cycle Execute sequencer: holds the pipeline for MC_LAT-1 cycles and
// pulses MCDoneE on the final Execute cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   MC_IDLE | no op in flight; MCStartE starts one (or finishes it at once
//           | when MC_LAT==1)
//   MC_BUSY | op in flight; cnt counts remaining stall cycles, done at 0
module mc_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MC_LAT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic MCStartE,
   output logic mcStall,
   output logic MCDoneE
);

   localparam int              CNT_W    = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
   localparam logic            MULTI    = (MC_LAT > 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = (MC_LAT > 1) ? CNT_W'(MC_LAT - 2) : '0;

   mc_state_t        state;
   logic [CNT_W-1:0] cnt;

   // State and down-counter; MCStartE is ignored while BUSY since the held
   // instruction keeps it asserted.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= MC_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            MC_IDLE: begin
               if (MCStartE && MULTI) begin
                  cnt   <= CNT_LOAD;
                  state <= MC_BUSY;
               end
            end
            MC_BUSY: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               else           state <= MC_IDLE;
            end
            default: state <= MC_IDLE;
         endcase
      end
   end

   // Stall must rise in the same cycle MCStartE is first seen, so these are
   // decoded from the current state rather than registered.
   always_comb begin
      mcStall = 1'b0;
      MCDoneE = 1'b0;
      if (reset_n) begin
         case (state)
            MC_IDLE: begin
               mcStall = MCStartE & MULTI;
               MCDoneE = MCStartE & ~MULTI;
            end
            MC_BUSY: begin
               mcStall = (cnt != '0);
               MCDoneE = (cnt == '0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Execute operand forwarding, load-use stall,
// branch/PC-write flushes, multi-cycle op hold and a stall-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NUM_SRC    = 3,
   parameter int REG_W      = 4,
   parameter int NO_FWD_REG = 15,
   parameter int MC_LAT     = 4,
   parameter int PERF_W     = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_SRC*REG_W-1:0] RAE,
   input  logic [REG_W-1:0]         RA1D,
   input  logic [REG_W-1:0]         RA2D,
   input  logic [REG_W-1:0]         WA3E,
   input  logic [REG_W-1:0]         WA3M,
   input  logic [REG_W-1:0]         WA3W,
   input  logic                     RegWriteE,
   input  logic                     RegWriteM,
   input  logic                     RegWriteW,
   input  logic                     MemtoRegE,
   input  logic                     BranchTakenE,
   input  logic                     PCWrPendingF,
   input  logic                     PCSrcW,
   input  logic                     MCStartE,
   output logic [NUM_SRC*2-1:0]     ForwardE,
   output logic                     StallF,
   output logic                     StallD,
   output logic                     StallE,
   output logic                     FlushD,
   output logic                     FlushE,
   output logic                     MCDoneE,
   output logic [PERF_W-1:0]        StallCount
);

   localparam logic [REG_W-1:0] NO_FWD = REG_W'(NO_FWD_REG);

   logic ld_stall;
   logic mc_stall;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      logic [REG_W-1:0] ra;
      fwd_sel_t         sel;

      assign ra = RAE[i*REG_W +: REG_W];

      // Memory stage result is newer than Writeback, so it wins; the PC is
      // never forwarded because the datapath supplies PC+8 itself.
      always_comb begin
         sel = FWD_RF;
         if (ra != NO_FWD) begin
            if (RegWriteM && (ra == WA3M))      sel = FWD_M;
            else if (RegWriteW && (ra == WA3W)) sel = FWD_W;
         end
      end

      assign ForwardE[i*2 +: 2] = {2{reset_n}} & sel;
   end

   mc_stall_ctrl #(
      .MC_LAT (MC_LAT)
   ) u_mc (
      .clk      (clk),
      .reset_n  (reset_n),
      .MCStartE (MCStartE),
      .mcStall  (mc_stall),
      .MCDoneE  (MCDoneE)
   );

   // Stall and flush decode; reset forces bubbles into D and E with no holds.
   always_comb begin
      ld_stall = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
      StallE   = reset_n & mc_stall;
      StallD   = reset_n & (ld_stall | mc_stall);
      StallF   = reset_n & (ld_stall | mc_stall | PCWrPendingF);
      FlushD   = ~reset_n | PCWrPendingF | PCSrcW | BranchTakenE;
      FlushE   = ~reset_n | BranchTakenE | (ld_stall & ~mc_stall);
   end

   // Saturating count of Decode stall cycles.
   always_ff @(posedge clk) begin
      if (!reset_n)                          StallCount <= '0;
      else if (StallD && (StallCount != '1)) StallCount <= StallCount + PERF_W'(1);
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int PERF_W = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] RAE;
   logic [3:0]  RA1D, RA2D, WA3E, WA3M, WA3W;
   logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
   logic        BranchTakenE, PCWrPendingF, PCSrcW, MCStartE;
   logic [5:0]  ForwardE;
   logic        StallF, StallD, StallE, FlushD, FlushE, MCDoneE;
   logic [PERF_W-1:0] StallCount;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .NUM_SRC(3), .REG_W(4), .NO_FWD_REG(15), .MC_LAT(4), .PERF_W(PERF_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .RAE(RAE), .RA1D(RA1D), .RA2D(RA2D),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteE(RegWriteE),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
      .BranchTakenE(BranchTakenE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
      .MCStartE(MCStartE), .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD),
      .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE), .MCDoneE(MCDoneE),
      .StallCount(StallCount)
   );

   typedef struct {
      logic [11:0] rae;
      logic [3:0]  ra1d, ra2d, wa3e, wa3m, wa3w;
      logic        rwe, rwm, rww, mtr, br, pcwr, pcsrc;
      logic [5:0]  fwd;
      logic [4:0]  ctl;   // {StallF, StallD, StallE, FlushD, FlushE}
   } vec_t;

   vec_t vt[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr_in();
      RAE = '0; RA1D = 4'd1; RA2D = 4'd2; WA3E = 4'd7; WA3M = 4'd8; WA3W = 4'd9;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
      BranchTakenE = 0; PCWrPendingF = 0; PCSrcW = 0; MCStartE = 0;
   endtask

   task automatic set_ld();
      MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; RA2D = 4'd5;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      next_cyc();
      reset_n = 0;
      clr_in();
      next_cyc();
      next_cyc();
      reset_n = 1;
   endtask

   function automatic logic [4:0] ctl_now();
      return {StallF, StallD, StallE, FlushD, FlushE};
   endfunction

   initial begin
      //          rae      ra1d ra2d wa3e wa3m wa3w rwe rwm rww mtr br pcw pcs  fwd         ctl
      vt[0]  = '{12'h033, 4'd1, 4'd2, 4'd7, 4'd3, 4'd3, 0, 1, 1, 0, 0, 0, 0, 6'b00_10_10, 5'b00000};
      vt[1]  = '{12'h033, 4'd1, 4'd2, 4'd7, 4'd3, 4'd3, 0, 0, 1, 0, 0, 0, 0, 6'b00_01_01, 5'b00000};
      vt[2]  = '{12'hF33, 4'd1, 4'd2, 4'd7, 4'd15,4'd3, 0, 1, 1, 0, 0, 0, 0, 6'b00_01_01, 5'b00000};
      vt[3]  = '{12'hF74, 4'd1, 4'd2, 4'd7, 4'd4, 4'd15,0, 1, 1, 0, 0, 0, 0, 6'b00_00_10, 5'b00000};
      vt[4]  = '{12'h990, 4'd1, 4'd2, 4'd7, 4'd0, 4'd9, 0, 1, 1, 0, 0, 0, 0, 6'b01_01_10, 5'b00000};
      vt[5]  = '{12'h990, 4'd1, 4'd2, 4'd7, 4'd0, 4'd9, 0, 1, 0, 0, 0, 0, 0, 6'b00_00_10, 5'b00000};
      vt[6]  = '{12'h000, 4'd1, 4'd5, 4'd5, 4'd1, 4'd2, 1, 0, 0, 1, 0, 0, 0, 6'b00_00_00, 5'b11001};
      vt[7]  = '{12'h000, 4'd1, 4'd5, 4'd6, 4'd1, 4'd2, 1, 0, 0, 1, 0, 0, 0, 6'b00_00_00, 5'b00000};
      vt[8]  = '{12'h000, 4'd6, 4'd0, 4'd6, 4'd1, 4'd2, 0, 0, 0, 1, 0, 0, 0, 6'b00_00_00, 5'b00000};
      vt[9]  = '{12'h000, 4'd6, 4'd0, 4'd6, 4'd1, 4'd2, 1, 0, 0, 1, 0, 0, 0, 6'b00_00_00, 5'b11001};
      vt[10] = '{12'h000, 4'd1, 4'd2, 4'd7, 4'd1, 4'd2, 0, 0, 0, 0, 1, 0, 0, 6'b00_00_00, 5'b00011};
      vt[11] = '{12'h000, 4'd1, 4'd2, 4'd7, 4'd1, 4'd2, 0, 0, 0, 0, 0, 1, 0, 6'b00_00_00, 5'b10010};
      vt[12] = '{12'h000, 4'd1, 4'd2, 4'd7, 4'd1, 4'd2, 0, 0, 0, 0, 0, 0, 1, 6'b00_00_00, 5'b00010};
      vt[13] = '{12'h000, 4'd1, 4'd5, 4'd5, 4'd1, 4'd2, 1, 0, 0, 1, 1, 0, 0, 6'b00_00_00, 5'b11011};
      vt[14] = '{12'h000, 4'd1, 4'd5, 4'd5, 4'd1, 4'd2, 1, 0, 0, 1, 0, 1, 0, 6'b00_00_00, 5'b11011};

      reset_n = 0;
      clr_in();

      // Reset overrides: forwarding match and load-use present, yet no
      // holds, no forwarding, both flushes high.
      RAE = 12'h033; WA3M = 4'd3; RegWriteM = 1; set_ld();
      next_cyc();
      next_cyc();
      @(negedge clk);
      chk("rst_fwd", ForwardE, 6'd0);
      chk("rst_ctl", ctl_now(), 5'b00011);
      chk("rst_done", MCDoneE, 1'b0);
      next_cyc();
      clr_in();
      reset_n = 1;
      @(negedge clk);
      chk("rst_cnt", StallCount, 0);

      // Combinational vector table.
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         RAE = vt[i].rae; RA1D = vt[i].ra1d; RA2D = vt[i].ra2d;
         WA3E = vt[i].wa3e; WA3M = vt[i].wa3m; WA3W = vt[i].wa3w;
         RegWriteE = vt[i].rwe; RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww;
         MemtoRegE = vt[i].mtr; BranchTakenE = vt[i].br;
         PCWrPendingF = vt[i].pcwr; PCSrcW = vt[i].pcsrc;
         #1;
         chk($sformatf("vec%0d_fwd", i), ForwardE, vt[i].fwd);
         chk($sformatf("vec%0d_ctl", i), ctl_now(), vt[i].ctl);
      end

      // Multi-cycle op, MCStartE held: 3 stall cycles, done on the 4th,
      // then a back-to-back op restarts in cycle 5.
      do_reset();
      MCStartE = 1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("mc_stalle_c%0d", k), StallE, (k <= 3 || k == 5) ? 1 : 0);
         chk($sformatf("mc_stalld_c%0d", k), StallD, (k <= 3 || k == 5) ? 1 : 0);
         chk($sformatf("mc_done_c%0d", k), MCDoneE, (k == 4) ? 1 : 0);
         chk($sformatf("mc_flushe_c%0d", k), FlushE, 0);
         if (k == 5) chk("mc_stallcount", StallCount, 3);
         next_cyc();
      end

      // Same op with a concurrent load-use: no E bubble while the op is held.
      do_reset();
      MCStartE = 1;
      set_ld();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("mcld_stalle_c%0d", k), StallE, (k <= 3) ? 1 : 0);
         chk($sformatf("mcld_flushe_c%0d", k), FlushE, (k == 4) ? 1 : 0);
         chk($sformatf("mcld_stalld_c%0d", k), StallD, 1);
         chk($sformatf("mcld_done_c%0d", k), MCDoneE, (k == 4) ? 1 : 0);
         next_cyc();
      end

      // Reset during the second BUSY cycle.
      do_reset();
      MCStartE = 1;        // cycle 1: IDLE, op starts
      next_cyc();          // cycle 2: first BUSY cycle
      next_cyc();          // cycle 3: second BUSY cycle
      reset_n = 0;
      MCStartE = 0;
      @(negedge clk);
      chk("mrst_stalle", StallE, 0);
      chk("mrst_ctl", ctl_now(), 5'b00011);
      chk("mrst_done", MCDoneE, 0);
      next_cyc();
      reset_n = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("mrst_after_stalle%0d", k), StallE, 0);
         chk($sformatf("mrst_after_done%0d", k), MCDoneE, 0);
         if (k == 0) chk("mrst_after_cnt", StallCount, 0);
         next_cyc();
      end

      // StallCount saturation with a held load-use stall.
      do_reset();
      set_ld();
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         chk($sformatf("sat_c%0d", k), StallCount, (k - 1 > 15) ? 15 : k - 1);
         next_cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
